// File: rtl/mem_arbiter.sv
// N-port round-robin memory front end with an internal byte-enabled RAM, wait states and bursts.
// Define MEM_ARBITER_PRIO0_EN to give port 0 fixed priority over the round-robin ports.
module mem_arbiter #(
  parameter int unsigned N_PORTS     = 2,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic [N_PORTS-1:0]     CLAIM,
  input  logic [32*N_PORTS-1:0]  ADDR,
  input  logic [N_PORTS-1:0]     WRITE,
  input  logic [3*N_PORTS-1:0]   SIZE,
  input  logic [3*N_PORTS-1:0]   BURST,
  input  logic [32*N_PORTS-1:0]  WRITE_DATA,
  output logic [32*N_PORTS-1:0]  READ_DATA,
  output logic [N_PORTS-1:0]     READYOUT,
  output logic [N_PORTS-1:0]     RESP
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned GW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_BEAT = 2'd2;
  localparam logic [1:0] S_NEXT = (WAIT_STATES == 0) ? S_BEAT : S_WAIT;

  logic [1:0]            r_state;
  logic [GW-1:0]         r_gnt;
  logic [GW-1:0]         r_ptr;
  logic [31:0]           r_addr;
  logic                  r_write;
  logic [2:0]            r_size;
  logic [2:0]            r_burst;
  logic [3:0]            r_cnt;
  logic [32*N_PORTS-1:0] r_rdata;
  logic [N_PORTS-1:0]    r_ready;
  logic [N_PORTS-1:0]    r_resp;
  logic [31:0]           r_mem [DEPTH];

  logic          w_found;
  logic [GW-1:0] w_win;
  logic [31:0]   w_win_addr;
  logic          w_win_write;
  logic [2:0]    w_win_size;
  logic [2:0]    w_win_burst;
  logic          w_claim_g;
  logic [31:0]   w_wdata;
  logic [AW-1:0] w_idx;
  logic          w_err;
  logic [3:0]    w_strb;

  // Round-robin: ports above the pointer first, then wrap around to the pointer itself.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (!w_found && CLAIM[p] && (p > int'(r_ptr))) begin
        w_found = 1'b1;
        w_win   = GW'(p);
      end
    end
    for (int p = 0; p < N_PORTS; p++) begin
      if (!w_found && CLAIM[p] && (p <= int'(r_ptr))) begin
        w_found = 1'b1;
        w_win   = GW'(p);
      end
    end
`ifdef MEM_ARBITER_PRIO0_EN
    if (CLAIM[0]) w_win = '0;
`endif
  end

  always_comb begin
    w_win_addr  = '0;
    w_win_write = 1'b0;
    w_win_size  = '0;
    w_win_burst = '0;
    w_claim_g   = 1'b0;
    w_wdata     = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (w_win == GW'(p)) begin
        w_win_addr  = ADDR[p*32 +: 32];
        w_win_write = WRITE[p];
        w_win_size  = SIZE[p*3 +: 3];
        w_win_burst = BURST[p*3 +: 3];
      end
      if (r_gnt == GW'(p)) begin
        w_claim_g = CLAIM[p];
        w_wdata   = WRITE_DATA[p*32 +: 32];
      end
    end
  end

  always_comb begin
    w_idx = r_addr[AW+1:2];
    w_err = (|(r_addr >> (AW + 2))) || (r_size > 3'd2) ||
            ((r_size == 3'd1) && r_addr[0]) ||
            ((r_size == 3'd2) && (r_addr[1:0] != 2'b00));
    case (r_size)
      3'd0:    w_strb = 4'b0001 << r_addr[1:0];
      3'd1:    w_strb = r_addr[1] ? 4'b1100 : 4'b0011;
      default: w_strb = 4'b1111;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RSTN) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_ptr   <= GW'(N_PORTS - 1);
      r_addr  <= '0;
      r_write <= 1'b0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_ready <= '0;
      r_resp  <= '0;
    end else begin
      r_ready <= '0;
      r_resp  <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt   <= w_win;
            r_addr  <= w_win_addr;
            r_write <= w_win_write;
            r_size  <= w_win_size;
            r_burst <= w_win_burst;
            r_cnt   <= 4'(WAIT_STATES);
            r_state <= S_NEXT;
`ifdef MEM_ARBITER_PRIO0_EN
            if (w_win != '0) r_ptr <= w_win;
`else
            r_ptr   <= w_win;
`endif
          end
        end
        S_WAIT: begin
          // A master dropping CLAIM before its next beat starts ends the burst here.
          if (!w_claim_g) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) r_state <= S_BEAT;
          end
        end
        S_BEAT: begin
          for (int p = 0; p < N_PORTS; p++) begin
            if (r_gnt == GW'(p)) begin
              r_ready[p] <= 1'b1;
              r_resp[p]  <= w_err;
              if (!r_write && !w_err) r_rdata[p*32 +: 32] <= r_mem[w_idx];
            end
          end
          if ((r_burst != 3'd0) && w_claim_g) begin
            // Only the word index advances, so bursts wrap inside the RAM.
            r_addr[AW+1:2] <= w_idx + 1'b1;
            r_burst        <= r_burst - 3'd1;
            r_cnt          <= 4'(WAIT_STATES);
            r_state        <= S_NEXT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN && (r_state == S_BEAT) && r_write && !w_err) begin
      for (int l = 0; l < 4; l++) begin
        if (w_strb[l]) r_mem[w_idx][l*8 +: 8] <= w_wdata[l*8 +: 8];
      end
    end
  end

  assign READ_DATA = r_rdata;
  assign READYOUT  = r_ready;
  assign RESP      = r_resp;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (2 ports, DEPTH 1024, one wait state).
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic [1:0]  CLAIM;
  logic [63:0] ADDR;
  logic [1:0]  WRITE;
  logic [5:0]  SIZE;
  logic [5:0]  BURST;
  logic [63:0] WRITE_DATA;
  logic [63:0] READ_DATA;
  logic [1:0]  READYOUT;
  logic [1:0]  RESP;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(
    .N_PORTS(2),
    .DEPTH(1024),
    .WAIT_STATES(1)
  ) dut (
    .CLK(CLK),
    .RSTN(RSTN),
    .CLAIM(CLAIM),
    .ADDR(ADDR),
    .WRITE(WRITE),
    .SIZE(SIZE),
    .BURST(BURST),
    .WRITE_DATA(WRITE_DATA),
    .READ_DATA(READ_DATA),
    .READYOUT(READYOUT),
    .RESP(RESP)
  );

  task automatic set_req(input int p, input logic [31:0] a, input logic w, input logic [2:0] s,
                         input logic [2:0] b, input logic [31:0] d);
    ADDR[p*32 +: 32]       = a;
    WRITE[p]               = w;
    SIZE[p*3 +: 3]         = s;
    BURST[p*3 +: 3]        = b;
    WRITE_DATA[p*32 +: 32] = d;
    CLAIM[p]               = 1'b1;
  endtask

  // Counts negedges until READYOUT[p]; ok stays 0 if the bound expires.
  task automatic wait_ready(input int p, output int cyc, output logic ok);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      if (READYOUT[p]) begin
        cyc = i;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_single(input int p, input logic [31:0] a, input logic w, input logic [2:0] s,
                           input logic [31:0] d, output logic [31:0] rd, output logic rs,
                           output int cyc, output logic ok);
    set_req(p, a, w, s, 3'd0, d);
    wait_ready(p, cyc, ok);
    rd = READ_DATA[p*32 +: 32];
    rs = RESP[p];
    CLAIM[p] = 1'b0;
  endtask

  task automatic test_reset;
    CLAIM = '0; ADDR = '0; WRITE = '0; SIZE = '0; BURST = '0; WRITE_DATA = '0;
    RSTN = 1'b1;
    repeat (3) @(negedge CLK);
    checks++; if (READYOUT !== 2'b00) begin failures++;
      $display("FAIL reset_readyout got=%b want=00", READYOUT); end
    checks++; if (RESP !== 2'b00) begin failures++;
      $display("FAIL reset_resp got=%b want=00", RESP); end
    checks++; if (READ_DATA !== 64'h0) begin failures++;
      $display("FAIL reset_read_data got=%h want=0", READ_DATA); end
    RSTN = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_read_after_write;
    logic [31:0] rd; logic rs; int cyc; logic ok;
    do_single(0, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF, rd, rs, cyc, ok);
    checks++; if (!ok || cyc != 3) begin failures++;
      $display("FAIL raw_write_latency got=%0d want=3", cyc); end
    checks++; if (rs !== 1'b0) begin failures++;
      $display("FAIL raw_write_resp got=%b want=0", rs); end
    do_single(0, 32'h10, 1'b0, 3'd2, 32'h0, rd, rs, cyc, ok);
    checks++; if (!ok || cyc != 3) begin failures++;
      $display("FAIL raw_read_latency got=%0d want=3", cyc); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++;
      $display("FAIL raw_read_data got=%h want=deadbeef", rd); end
    checks++; if (rs !== 1'b0) begin failures++;
      $display("FAIL raw_read_resp got=%b want=0", rs); end
    @(negedge CLK);
    checks++; if (READYOUT[0] !== 1'b0) begin failures++;
      $display("FAIL raw_pulse_width got=%b want=0", READYOUT[0]); end
    checks++; if (READ_DATA[31:0] !== 32'hDEADBEEF) begin failures++;
      $display("FAIL raw_read_hold got=%h want=deadbeef", READ_DATA[31:0]); end
  endtask

  task automatic test_byte_write;
    logic [31:0] rd; logic rs; int cyc; logic ok;
    do_single(1, 32'h10, 1'b1, 3'd2, 32'h11223344, rd, rs, cyc, ok);
    do_single(1, 32'h13, 1'b1, 3'd0, 32'hAA000000, rd, rs, cyc, ok);
    checks++; if (!ok || rs !== 1'b0) begin failures++;
      $display("FAIL byte_write_resp got=%b ok=%b want=0", rs, ok); end
    do_single(1, 32'h10, 1'b0, 3'd2, 32'h0, rd, rs, cyc, ok);
    checks++; if (!ok || rd !== 32'hAA223344) begin failures++;
      $display("FAIL byte_write_data got=%h want=aa223344", rd); end
    do_single(1, 32'h12, 1'b1, 3'd1, 32'h55660000, rd, rs, cyc, ok);
    do_single(1, 32'h10, 1'b1, 3'd0, 32'h000000EE, rd, rs, cyc, ok);
    do_single(1, 32'h10, 1'b0, 3'd2, 32'h0, rd, rs, cyc, ok);
    checks++; if (!ok || rd !== 32'h556633EE) begin failures++;
      $display("FAIL half_byte_write_data got=%h want=556633ee", rd); end
  endtask

  task automatic test_simultaneous;
    int order[4]; int when[4]; int exp_order[4]; int cnt[2]; int n;
`ifdef MEM_ARBITER_PRIO0_EN
    exp_order = '{0, 0, 1, 1};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    n = 0; cnt[0] = 0; cnt[1] = 0;
    RSTN = 1'b1;
    @(negedge CLK);
    RSTN = 1'b0;
    // Each port asks for two single reads back to back, both starting in the same cycle.
    set_req(0, 32'h10, 1'b0, 3'd2, 3'd0, 32'h0);
    set_req(1, 32'h10, 1'b0, 3'd2, 3'd0, 32'h0);
    for (int i = 1; i <= 60 && n < 4; i++) begin
      @(negedge CLK);
      for (int p = 0; p < 2; p++) begin
        if (READYOUT[p] && n < 4) begin
          order[n] = p; when[n] = i; n++;
          cnt[p]++;
          if (cnt[p] == 2) CLAIM[p] = 1'b0;
        end
      end
    end
    CLAIM = '0;
    checks++; if (n != 4) begin failures++;
      $display("FAIL sim_pulse_count got=%0d want=4", n); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (k < n && order[k] != exp_order[k]) begin failures++;
        $display("FAIL sim_order_%0d got=%0d want=%0d", k, order[k], exp_order[k]); end
    end
    checks++; if (n < 2 || when[0] != 3 || when[1] - when[0] != 3) begin failures++;
      $display("FAIL sim_timing got=%0d,%0d want=3,6", when[0], when[1]); end
  endtask

  task automatic test_wrap_burst;
    logic [31:0] wd[4]; logic [31:0] rd; logic rs; int cyc; logic ok;
    wd = '{32'hA0A00001, 32'hB0B00002, 32'hC0C00003, 32'hD0D00004};
    set_req(0, 32'hFF8, 1'b1, 3'd2, 3'd3, wd[0]);
    for (int b = 0; b < 4; b++) begin
      wait_ready(0, cyc, ok);
      checks++; if (!ok || cyc != ((b == 0) ? 3 : 2) || RESP[0] !== 1'b0) begin failures++;
        $display("FAIL wrap_write_beat%0d cyc=%0d resp=%b want cyc=%0d resp=0",
                 b, cyc, RESP[0], (b == 0) ? 3 : 2); end
      if (b < 3) WRITE_DATA[31:0] = wd[b+1];
    end
    CLAIM[0] = 1'b0;
    set_req(0, 32'hFF8, 1'b0, 3'd2, 3'd3, 32'h0);
    for (int b = 0; b < 4; b++) begin
      wait_ready(0, cyc, ok);
      checks++;
      if (!ok || cyc != ((b == 0) ? 3 : 2) || RESP[0] !== 1'b0 || READ_DATA[31:0] !== wd[b]) begin
        failures++;
        $display("FAIL wrap_read_beat%0d cyc=%0d resp=%b data=%h want data=%h resp=0",
                 b, cyc, RESP[0], READ_DATA[31:0], wd[b]); end
    end
    CLAIM[0] = 1'b0;
    do_single(0, 32'h0, 1'b0, 3'd2, 32'h0, rd, rs, cyc, ok);
    checks++; if (!ok || rd !== wd[2]) begin failures++;
      $display("FAIL wrap_word0 got=%h want=%h", rd, wd[2]); end
    do_single(0, 32'h1000, 1'b0, 3'd2, 32'h0, rd, rs, cyc, ok);
    checks++; if (!ok || rs !== 1'b1) begin failures++;
      $display("FAIL out_of_range_resp got=%b want=1", rs); end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic rs; int cyc; logic ok;
    do_single(0, 32'h0, 1'b1, 3'd2, 32'h12345678, rd, rs, cyc, ok);
    do_single(0, 32'h2, 1'b1, 3'd2, 32'hFFFFFFFF, rd, rs, cyc, ok);
    checks++; if (!ok || rs !== 1'b1) begin failures++;
      $display("FAIL err_misaligned_word_write got=%b want=1", rs); end
    do_single(0, 32'h1, 1'b1, 3'd1, 32'hFFFFFFFF, rd, rs, cyc, ok);
    checks++; if (!ok || rs !== 1'b1) begin failures++;
      $display("FAIL err_misaligned_half_write got=%b want=1", rs); end
    do_single(0, 32'h0, 1'b0, 3'd2, 32'h0, rd, rs, cyc, ok);
    checks++; if (!ok || rd !== 32'h12345678 || rs !== 1'b0) begin failures++;
      $display("FAIL err_ram_unchanged got=%h resp=%b want=12345678 resp=0", rd, rs); end
    do_single(0, 32'h2, 1'b0, 3'd2, 32'h0, rd, rs, cyc, ok);
    checks++; if (!ok || rs !== 1'b1) begin failures++;
      $display("FAIL err_misaligned_word_read got=%b want=1", rs); end
    do_single(0, 32'h0, 1'b0, 3'd3, 32'h0, rd, rs, cyc, ok);
    checks++; if (!ok || rs !== 1'b1) begin failures++;
      $display("FAIL err_size3 got=%b want=1", rs); end
    // An erroring burst still runs every beat.
    set_req(0, 32'h1000, 1'b0, 3'd2, 3'd1, 32'h0);
    for (int b = 0; b < 2; b++) begin
      wait_ready(0, cyc, ok);
      checks++; if (!ok || RESP[0] !== 1'b1) begin failures++;
        $display("FAIL err_burst_beat%0d resp=%b ok=%b want=1", b, RESP[0], ok); end
    end
    CLAIM[0] = 1'b0;
  endtask

  task automatic test_abort;
    logic [31:0] rd; logic rs; int cyc; logic ok; int extra;
    set_req(1, 32'h10, 1'b0, 3'd2, 3'd3, 32'h0);
    wait_ready(1, cyc, ok);
    checks++; if (!ok) begin failures++;
      $display("FAIL abort_beat0 got=timeout want=pulse"); end
    wait_ready(1, cyc, ok);
    checks++; if (!ok || cyc != 2) begin failures++;
      $display("FAIL abort_beat1 cyc=%0d want=2", cyc); end
    CLAIM[1] = 1'b0;
    extra = 0;
    repeat (10) begin
      @(negedge CLK);
      if (READYOUT[1]) extra++;
    end
    checks++; if (extra != 0) begin failures++;
      $display("FAIL abort_extra_pulses got=%0d want=0", extra); end
    do_single(1, 32'h10, 1'b0, 3'd2, 32'h0, rd, rs, cyc, ok);
    checks++; if (!ok || cyc != 3 || rd !== 32'h556633EE) begin failures++;
      $display("FAIL abort_then_idle cyc=%0d data=%h want cyc=3 data=556633ee", cyc, rd); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic rs; int cyc; logic ok; int pulses;
    set_req(0, 32'h10, 1'b0, 3'd2, 3'd0, 32'h0);
    @(negedge CLK);
    RSTN = 1'b1;
    @(negedge CLK);
    checks++; if (READYOUT !== 2'b00 || RESP !== 2'b00) begin failures++;
      $display("FAIL midreset_flags got=%b/%b want=00/00", READYOUT, RESP); end
    checks++; if (READ_DATA !== 64'h0) begin failures++;
      $display("FAIL midreset_read_data got=%h want=0", READ_DATA); end
    RSTN = 1'b0;
    CLAIM[0] = 1'b0;
    pulses = 0;
    repeat (5) begin
      @(negedge CLK);
      if (READYOUT != 2'b00) pulses++;
    end
    checks++; if (pulses != 0) begin failures++;
      $display("FAIL midreset_no_pulse got=%0d want=0", pulses); end
    do_single(0, 32'h10, 1'b0, 3'd2, 32'h0, rd, rs, cyc, ok);
    checks++; if (!ok || cyc != 3 || rd !== 32'h556633EE) begin failures++;
      $display("FAIL midreset_recover cyc=%0d data=%h want cyc=3 data=556633ee", cyc, rd); end
  endtask

  initial begin
    test_reset();
    test_read_after_write();
    test_byte_write();
    test_simultaneous();
    test_wrap_burst();
    test_errors();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
